// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter: operand width, result record and
// round-robin pointer advance.
package adder_arb_pkg;

    localparam int unsigned W     = 8;
    // Widest requester ID supported (NREQ up to 8).
    localparam int unsigned IDMAX = 3;

    typedef struct packed {
        logic [W-1:0]     sum;
        logic             cout;
        logic [IDMAX-1:0] id;
    } res_t;

    function automatic logic [IDMAX-1:0] next_ptr(input logic [IDMAX-1:0] g,
                                                  input int unsigned      nreq);
        if (32'(g) == nreq - 1) begin
            return '0;
        end
        return g + IDMAX'(1);
    endfunction

endpackage

// File: rtl/adder_8b_8l.sv
// 8-bit Kogge-Stone prefix adder, purely combinational.
module adder_8b_8l (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);

    function automatic logic [8:0] ks_add(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] g, p, gn, pn, s;
        g  = x & y;
        p  = x ^ y;
        s  = p;
        gn = '0;
        pn = '0;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 8; i++) begin
                if (i >= (1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    pn[i] = p[i] & p[i - (1 << l)];
                end else begin
                    gn[i] = g[i];
                    pn[i] = p[i];
                end
            end
            g = gn;
            p = pn;
        end
        // g[i] is now the group carry out of bits [i:0].
        return {g[7], s ^ {g[6:0], 1'b0}};
    endfunction

    assign {cout, sum} = ks_add(a, b);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        int unsigned j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDW'(j);
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/adder_arbiter_8b.sv
// Round-robin arbitration of NREQ operand channels onto one shared 8-bit prefix adder,
// with a one-entry result register drained over a valid/ready channel.
module adder_arbiter_8b
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_cout,
    output logic [IDW-1:0]    res_id
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    res_t            res_q, res_d;
    logic            res_valid_q, res_valid_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx;
    logic            any;
    logic            can_accept;
    logic            accept;
    logic [W-1:0]    op_a, op_b;
    logic [W-1:0]    add_sum;
    logic            add_cout;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign op_a = req_a[idx*W +: W];
    assign op_b = req_b[idx*W +: W];

    adder_8b_8l u_add (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign can_accept = !res_valid_q || res_ready;
    assign accept     = any && can_accept;
    // Gate with rst_n so no requester sees a handshake while reset is held.
    assign req_ready  = (can_accept && rst_n) ? gnt : '0;

    always_comb begin
        ptr_d       = ptr_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        if (accept) begin
            res_d.sum   = add_sum;
            res_d.cout  = add_cout;
            res_d.id    = IDMAX'(idx);
            res_valid_d = 1'b1;
            ptr_d       = IDW'(next_ptr(IDMAX'(idx), NREQ));
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_q.sum;
    assign res_cout  = res_q.cout;
    assign res_id    = res_q.id[IDW-1:0];

endmodule

// File: tb/tb_adder_arbiter_8b.sv
// Self-checking bench for adder_arbiter_8b: directed scenarios plus random traffic
// compared against a behavioural model of the arbiter and result register.
module tb_adder_arbiter_8b;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_cout;
    logic [IDW-1:0]    res_id;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_ptr, m_sum, m_cout, m_id;
    bit m_valid;

    always #5 clk = ~clk;

    adder_arbiter_8b #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    function automatic int pick_model(logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        g = pick_model(req_valid);
        if (g < 0 || !(!m_valid || res_ready)) return '0;
        return NREQ'(1) << g;
    endfunction

    // Apply one rising edge to the model (inputs must be stable) and to the DUT.
    task automatic advance();
        int g, s;
        g = pick_model(req_valid);
        if (g >= 0 && (!m_valid || res_ready)) begin
            s       = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
            m_sum   = s % 256;
            m_cout  = s / 256;
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            m_valid = 1'b1;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_sum   = 0;
        m_cout  = 0;
        m_id    = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        res_ready = 1'b1;
        #3;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_ready got=%b want=0000", req_ready);
        end
        total++;
        if ({res_valid, res_sum, res_cout, res_id} !== '0) begin
            bad++; $display("FAIL reset_state got v=%b s=%h c=%b id=%0d want all 0",
                            res_valid, res_sum, res_cout, res_id);
        end
        do_reset();
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_a     = 32'h0000_000F;
        req_b     = 32'h0000_0001;
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_ready got=%b want=0001", req_ready);
        end
        advance();
        total++;
        if (res_valid !== 1'b1 || res_sum !== 8'h10 || res_cout !== 1'b0 || res_id !== 2'd0) begin
            bad++; $display("FAIL single_result got v=%b s=%h c=%b id=%0d want v=1 s=10 c=0 id=0",
                            res_valid, res_sum, res_cout, res_id);
        end
    endtask

    task automatic test_carry();
        req_valid = 4'b0100;
        req_a     = 32'h00FF_0000;
        req_b     = 32'h0001_0000;
        #1;
        advance();
        total++;
        if (res_valid !== 1'b1 || res_sum !== 8'h00 || res_cout !== 1'b1 || res_id !== 2'd2) begin
            bad++; $display("FAIL carry_result got v=%b s=%h c=%b id=%0d want v=1 s=00 c=1 id=2",
                            res_valid, res_sum, res_cout, res_id);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_a = $urandom;
            req_b = $urandom;
            #1;
            advance();
            total++;
            if (res_valid !== 1'b1 || res_id !== IDW'(k % NREQ) || res_sum !== m_sum[W-1:0]
                || res_cout !== m_cout[0]) begin
                bad++; $display("FAIL rr_cycle%0d got v=%b id=%0d s=%h c=%b want v=1 id=%0d s=%h c=%0d",
                                k, res_valid, res_id, res_sum, res_cout, k % NREQ, m_sum, m_cout);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_sum;
        logic         held_cout;
        do_reset();
        req_valid = 4'b0010;
        res_ready = 1'b1;
        req_a     = $urandom;
        req_b     = $urandom;
        #1;
        advance();
        held_sum  = m_sum[W-1:0];
        held_cout = m_cout[0];
        res_ready = 1'b0;
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_ready%0d got=%b want=0000", k, req_ready);
            end
            req_a = $urandom;
            req_b = $urandom;
            #1;
            advance();
            total++;
            if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== held_sum
                || res_cout !== held_cout) begin
                bad++; $display("FAIL bp_hold%0d got v=%b id=%0d s=%h c=%b want v=1 id=1 s=%h c=%b",
                                k, res_valid, res_id, res_sum, res_cout, held_sum, held_cout);
            end
        end
        res_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b1000) begin
            bad++; $display("FAIL bp_release_ready got=%b want=1000", req_ready);
        end
        advance();
        total++;
        if (res_valid !== 1'b1 || res_id !== 2'd3 || res_sum !== m_sum[W-1:0]) begin
            bad++; $display("FAIL bp_release got v=%b id=%0d s=%h want v=1 id=3 s=%h",
                            res_valid, res_id, res_sum, m_sum);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b1000;
        req_a     = $urandom;
        req_b     = $urandom;
        #1;
        advance();
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL sparse_ready got=%b want=0001", req_ready);
        end
        advance();
        total++;
        if (res_id !== 2'd0 || res_sum !== m_sum[W-1:0]) begin
            bad++; $display("FAIL sparse_id got id=%0d s=%h want id=0 s=%h", res_id, res_sum, m_sum);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        req_valid = 4'b0110;
        req_a     = $urandom;
        req_b     = $urandom;
        #1;
        advance();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({res_valid, res_sum, res_cout, res_id} !== '0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL midreset got v=%b s=%h c=%b id=%0d rdy=%b want all 0",
                            res_valid, res_sum, res_cout, res_id, req_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        m_ptr     = 0;
        m_valid   = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        advance();
        total++;
        if (res_valid !== 1'b1 || res_id !== 2'd0) begin
            bad++; $display("FAIL midreset_first got v=%b id=%0d want v=1 id=0", res_valid, res_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            req_valid = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            req_a     = $urandom;
            req_b     = $urandom;
            #1;
            total++;
            if (req_ready !== exp_ready()) begin
                bad++; $display("FAIL rand_ready%0d got=%b want=%b", k, req_ready, exp_ready());
            end
            advance();
            total++;
            if (res_valid !== m_valid || res_sum !== m_sum[W-1:0] || res_cout !== m_cout[0]
                || res_id !== IDW'(m_id)) begin
                bad++; $display("FAIL rand_res%0d got v=%b s=%h c=%b id=%0d want v=%b s=%h c=%0d id=%0d",
                                k, res_valid, res_sum, res_cout, res_id, m_valid, m_sum, m_cout, m_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
